// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the UART receiver
package uart_pkg;

    // Default frame geometry: 8 data bits, 16x oversampling, mid-bit at tick 7
    localparam int UART_NB_DATA    = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID_TICK   = 7;

    // Receiver FSM states, 2-bit binary
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset value chosen so the line looks idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled 8N1 UART receiver with framing-error flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = UART_NB_DATA,
    parameter int NB_STOP = UART_OVERSAMPLE,
    parameter int NB_TICK = UART_OVERSAMPLE
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int NB_NCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [3:0]         S_MID  = 4'(UART_MID_TICK);
    localparam logic [3:0]         S_BIT  = 4'(NB_TICK - 1);
    localparam logic [3:0]         S_STOP = 4'(NB_STOP - 1);
    localparam logic [NB_NCNT-1:0] N_LAST = NB_NCNT'(NB_DATA - 1);

    uart_state_t        state, state_n;
    logic [3:0]         s_cnt, s_cnt_n;
    logic [NB_NCNT-1:0] n_cnt, n_cnt_n;
    logic [NB_DATA-1:0] shreg, shreg_n;
    logic [NB_DATA-1:0] data_n;
    logic               done_n, err_n;
    logic               rx_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(i_rst_n),
        .d    (i_rx),
        .q    (rx_s)
    );

    // State, counters, shift register and registered strobes
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            s_cnt       <= '0;
            n_cnt       <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            s_cnt       <= s_cnt_n;
            n_cnt       <= n_cnt_n;
            shreg       <= shreg_n;
            o_data      <= data_n;
            o_rx_done   <= done_n;
            o_frame_err <= err_n;
        end
    end

    // Next-state logic; everything except the IDLE start detect waits for a tick
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        shreg_n = shreg;
        data_n  = o_data;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    s_cnt_n = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (s_cnt == S_MID) begin
                        if (!rx_s) begin
                            state_n = ST_DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            // start bit vanished by mid-bit: treat as a glitch
                            state_n = ST_IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (s_cnt == S_BIT) begin
                        shreg_n = {rx_s, shreg[NB_DATA-1:1]};
                        s_cnt_n = '0;
                        if (n_cnt == N_LAST) begin
                            state_n = ST_STOP;
                        end else begin
                            n_cnt_n = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (s_cnt == S_STOP) begin
                        if (rx_s) begin
                            data_n = shreg;
                            done_n = 1'b1;
                        end else begin
                            err_n = 1'b1;
                        end
                        state_n = ST_IDLE;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc        = 0;
    int tick_div   = 1;
    int tick_phase = 0;

    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;
    int         busy_cyc = 0;
    logic [7:0] done_q[$];
    int         done_cyc_q[$];

    uart_rx dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and baud tick (one clk wide every tick_div clocks)
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        tick_phase = (tick_phase + 1) % tick_div;
        i_tick = (tick_phase == 0);
    end

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (o_rx_done) begin
            done_cnt = done_cnt + 1;
            done_q.push_back(o_data);
            done_cyc_q.push_back(cyc);
        end
        if (o_frame_err) err_cnt = err_cnt + 1;
        if (o_rx_done && o_frame_err) both_cnt = both_cnt + 1;
        if (o_busy) busy_cyc = busy_cyc + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic v, input int n);
        i_rx = v;
        wait_cycles(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        send_bit(stop, cpb);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        i_tick  = 1'b1;
        wait_cycles(4);
        n_checks += 4;
        if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", o_data); end
        if (o_rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_rx_done); end
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", o_frame_err); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        i_rst_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_single_frame;
        int d0, e0, b0, start_cyc, lat;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 16);
        n_checks += 4;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL a5_done_count: got %0d expected 1", done_cnt - d0); end
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL a5_err_count: got %0d expected 0", err_cnt - e0); end
        if (o_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %0h expected a5", o_data); end
        if ((busy_cyc - b0) < 151 || (busy_cyc - b0) > 153) begin
            n_fail++; $display("FAIL a5_busy_cycles: got %0d expected 152", busy_cyc - b0);
        end
        if (done_cnt - d0 == 1) begin
            lat = done_cyc_q[done_cyc_q.size() - 1] - start_cyc - 1;
            n_checks++;
            if (lat < 153 || lat > 155) begin n_fail++; $display("FAIL a5_latency: got %0d expected 154", lat); end
        end
        wait_cycles(8);
    endtask

    task automatic test_back_to_back;
        int q0, gap;
        q0 = done_q.size();
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        wait_cycles(8);
        n_checks++;
        if (done_q.size() - q0 !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 2", done_q.size() - q0);
        end else begin
            gap = done_cyc_q[q0 + 1] - done_cyc_q[q0];
            n_checks += 3;
            if (done_q[q0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %0h expected 0", done_q[q0]); end
            if (done_q[q0 + 1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %0h expected ff", done_q[q0 + 1]); end
            if (gap !== 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 160", gap); end
        end
    endtask

    task automatic test_frame_error;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 16);
        send_bit(1'b1, 40);
        n_checks += 3;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_err_count: got %0d expected 1", err_cnt - e0); end
        if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ferr_done_count: got %0d expected 0", done_cnt - d0); end
        if (o_data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data: got %0h expected ff", o_data); end
    endtask

    task automatic test_glitch;
        int d0, e0, b0;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
        send_bit(1'b0, 5);
        send_bit(1'b1, 30);
        n_checks += 3;
        if ((busy_cyc - b0) < 7 || (busy_cyc - b0) > 9) begin
            n_fail++; $display("FAIL glitch_busy_cycles: got %0d expected 8", busy_cyc - b0);
        end
        if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", (done_cnt - d0) + (err_cnt - e0));
        end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", o_busy); end
    endtask

    task automatic test_reset_mid_frame;
        int d0, e0;
        logic [7:0] pre;
        pre = 8'h5A;
        d0 = done_cnt; e0 = err_cnt;
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(pre[i], 16);
        send_bit(pre[4], 8);
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        #1;
        n_checks += 4;
        if (o_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %0h expected 0", o_data); end
        if (o_rx_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", o_rx_done); end
        if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", o_frame_err); end
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", o_busy); end
        wait_cycles(3);
        i_rst_n = 1'b1;
        wait_cycles(200);
        n_checks++;
        if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL rst_mid_aborted_strobes: got %0d expected 0", (done_cnt - d0) + (err_cnt - e0));
        end
        send_frame(8'h81, 1'b1, 16);
        wait_cycles(8);
        n_checks += 2;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rst_mid_done_count: got %0d expected 1", done_cnt - d0); end
        if (o_data !== 8'h81) begin n_fail++; $display("FAIL rst_mid_next_data: got %0h expected 81", o_data); end
    endtask

    task automatic test_slow_tick;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        tick_div = 4;
        send_frame(8'hC3, 1'b1, 64);
        wait_cycles(16);
        n_checks += 3;
        if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL slow_done_count: got %0d expected 1", done_cnt - d0); end
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL slow_err_count: got %0d expected 0", err_cnt - e0); end
        if (o_data !== 8'hC3) begin n_fail++; $display("FAIL slow_data: got %0h expected c3", o_data); end
        tick_div = 1;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        i_tick  = 1'b1;
        @(posedge clk);
        #2;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_frame_error;
        test_glitch;
        test_reset_mid_frame;
        test_slow_tick;
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL strobes_exclusive: got %0d expected 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
